// File: rtl/cpu_pkg.sv
// cpu_pkg: shared next-PC codes, fetch state encoding and reset PC
package cpu_pkg;
  localparam logic [3:0] PC_PLUS4 = 4'b0000;
  localparam logic [3:0] PC_BR_Z  = 4'b0001;
  localparam logic [3:0] PC_BR_NZ = 4'b0010;
  localparam logic [3:0] PC_JALR  = 4'b0111;
  localparam logic [3:0] PC_JAL   = 4'b1000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, ERR} fetch_state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection with alignment check
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [3:0]      pc_select,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);
  logic taken;
  // branches test alu_result against zero; jal is always taken; jalr clears bit 0 only
  always_comb begin
    taken = (pc_select == PC_JAL) ||
            (pc_select == PC_BR_Z && alu_result == '0) ||
            (pc_select == PC_BR_NZ && alu_result != '0);
    next_pc = (pc_select == PC_JALR) ? {alu_result[XLEN-1:1], 1'b0} :
              taken ? pc + imm : pc + XLEN'(4);
    misaligned = next_pc[1:0] != 2'b00;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing and single-outstanding instruction fetch
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      pc_select,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] imm,
  input  logic            retire,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);
  fetch_state_t state;
  logic [XLEN-1:0] next_pc;
  logic            next_bad;
  next_pc_calc #(.XLEN(XLEN)) u_next (
    .pc         (pc),
    .pc_select  (pc_select),
    .alu_result (alu_result),
    .imm        (imm),
    .next_pc    (next_pc),
    .misaligned (next_bad)
  );
  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);
  // fetch sequencer: request, await response, hold for execute, then advance or trap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      instr          <= '0;
      instr_valid    <= 1'b0;
      imem_req_valid <= 1'b0;
      misaligned     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end
        REQ: if (imem_req_ready) begin
          state          <= WAIT;
          imem_req_valid <= 1'b0;
        end
        WAIT: if (imem_rsp_valid) begin
          state       <= EXEC;
          instr       <= imem_rdata;
          instr_valid <= 1'b1;
        end
        EXEC: if (retire) begin
          instr_valid <= 1'b0;
          if (next_bad) begin
            state      <= ERR;
            misaligned <= 1'b1;
          end else begin
            state          <= REQ;
            pc             <= next_pc;
            imem_req_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a transaction-level reference model
module tb_fetch_unit;
  logic        clk = 0, reset = 1;
  logic [3:0]  pc_select = 0;
  logic [31:0] alu_result = 0, imm = 0, imem_rdata = 0;
  logic        retire = 0, imem_req_ready = 0, imem_rsp_valid = 0;
  logic        imem_req_valid, instr_valid, misaligned;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  int errors = 0, checks = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pc_select(pc_select), .alu_result(alu_result),
    .imm(imm), .retire(retire), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: what the next PC must be for a retired instruction
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [3:0] sel,
                                           input logic [31:0] alu, input logic [31:0] im);
    case (sel)
      4'b0001: return (alu == 0) ? p + im : p + 4;
      4'b0010: return (alu != 0) ? p + im : p + 4;
      4'b0111: return alu & 32'hFFFF_FFFE;
      4'b1000: return p + im;
      default: return p + 4;
    endcase
  endfunction

  // transaction-level model: started / requesting / awaiting / holding / trapped
  logic [31:0] m_pc, m_instr;
  logic m_started, m_req, m_await, m_hold, m_trap;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 0; m_instr <= 0; m_started <= 0; m_req <= 0;
      m_await <= 0; m_hold <= 0; m_trap <= 0;
    end else if (m_trap) begin
    end else if (!m_started) begin
      m_started <= 1; m_req <= 1;
    end else if (m_req) begin
      if (imem_req_ready) begin m_req <= 0; m_await <= 1; end
    end else if (m_await) begin
      if (imem_rsp_valid) begin m_instr <= imem_rdata; m_hold <= 1; m_await <= 0; end
    end else if (m_hold && retire) begin
      m_hold <= 0;
      if (ref_next(m_pc, pc_select, alu_result, imm) % 4 != 0) m_trap <= 1;
      else begin m_pc <= ref_next(m_pc, pc_select, alu_result, imm); m_req <= 1; end
    end
  end

  // every cycle out of reset, all outputs must match the model
  always @(negedge clk) if (!reset) begin
    chk("m_req_valid", {31'b0, imem_req_valid}, {31'b0, m_req});
    chk("m_addr", imem_addr, m_pc);
    chk("m_pc", pc, m_pc);
    chk("m_pc_plus4", pc_plus4, m_pc + 4);
    chk("m_instr", instr, m_instr);
    chk("m_instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
    chk("m_misaligned", {31'b0, misaligned}, {31'b0, m_trap});
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_req(input logic [31:0] addr);
    for (int i = 0; i < 20 && !imem_req_valid; i++) step();
    chk("req_seen", {31'b0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, addr);
  endtask

  task automatic fetch(input logic [31:0] data, input int stall);
    logic [31:0] a, old;
    a = imem_addr; old = instr;
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 0;
      imem_rsp_valid = (i == 1);
      imem_rdata = 32'hDEAD_BEEF;
      step();
      chk("stall_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_addr, a);
      chk("stall_instr", instr, old);
    end
    imem_rsp_valid = 0;
    imem_req_ready = 1; step();
    imem_req_ready = 0; imem_rsp_valid = 1; imem_rdata = data; step();
    imem_rsp_valid = 0;
    chk("fetch_instr", instr, data);
    chk("fetch_valid", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic do_retire(input logic [3:0] sel, input logic [31:0] alu, input logic [31:0] im);
    pc_select = sel; alu_result = alu; imm = im; retire = 1;
    step();
    retire = 0;
  endtask

  initial begin
    step(); step();
    chk("rst_req", {31'b0, imem_req_valid}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_ivalid", {31'b0, instr_valid}, 0);
    chk("rst_mis", {31'b0, misaligned}, 0);
    reset = 0;
    wait_req(32'h0);
    fetch(32'h0050_0093, 0);
    chk("first_pc", pc, 0);
    do_retire(4'b0000, 0, 0);          wait_req(32'h4);  fetch(32'h1, 0);
    chk("pc_plus4_at4", pc_plus4, 32'h8);
    do_retire(4'b1000, 0, 32'hC);      wait_req(32'h10); fetch(32'h2, 0);
    do_retire(4'b0001, 0, 32'h20);     wait_req(32'h30); fetch(32'h3, 0);
    do_retire(4'b1000, 0, 32'hFFFF_FFE0); wait_req(32'h10); fetch(32'h4, 0);
    do_retire(4'b0001, 5, 32'h20);     wait_req(32'h14); fetch(32'h5, 0);
    do_retire(4'b1000, 0, 32'hFFFF_FFFC); wait_req(32'h10); fetch(32'h6, 0);
    do_retire(4'b0010, 1, 32'h20);     wait_req(32'h30); fetch(32'h7, 0);
    do_retire(4'b0111, 32'h101, 0);    wait_req(32'h100);
    fetch(32'h8, 5);
    do_retire(4'b0111, 32'h103, 0);
    chk("err_mis", {31'b0, misaligned}, 1);
    chk("err_pc", pc, 32'h100);
    retire = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("err_req", {31'b0, imem_req_valid}, 0);
      chk("err_ivalid", {31'b0, instr_valid}, 0);
    end
    retire = 0;
    reset = 1; step(); reset = 0;
    wait_req(32'h0); fetch(32'h9, 0);
    do_retire(4'b0111, 32'h40, 0);     wait_req(32'h40);
    imem_req_ready = 1; step(); imem_req_ready = 0;
    #1 reset = 1;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_req", {31'b0, imem_req_valid}, 0);
    chk("arst_instr", instr, 0);
    chk("arst_ivalid", {31'b0, instr_valid}, 0);
    step(); reset = 0;
    wait_req(32'h0); fetch(32'hA, 0);
    do_retire(4'b0111, 32'hFFFF_FFFC, 0); wait_req(32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 0);
    fetch(32'hB, 0);
    do_retire(4'b1000, 0, 32'h8);      wait_req(32'h4);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
